// File: rtl/multicycle_processor_if.sv
// Memory bus shared by instruction fetch and data access.
// master (core): drives mem_req, mem_we, mem_addr, mem_wdata; samples mem_rdata, mem_ready.
// slave (memory): the reverse. An access completes on the rising edge where
// mem_req and mem_ready are both high.
interface multicycle_processor_if #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_SIZE-1:0]  mem_wdata;
    logic [WORD_SIZE-1:0]  mem_rdata;
    logic                  mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/multicycle_processor.sv
// Multi-cycle MIPS-subset core: one shared ALU, one shared memory port with
// req/ready handshake, internal register file.
// Ports:
//   clk, rst (async, active-low)
//   mem_bus        memory master port (see multicycle_processor_if)
//   prog_count     PC of the instruction in flight
//   instr_opcode   IR[31:26]
//   write_reg_*    register-file write strobe, address and data (combinational)
//   instr_retired  pulse in the final cycle of each instruction
//   halted/illegal sticky halt status; illegal marks bad opcode/funct/alignment
module multicycle_processor #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_processor_if.master     mem_bus,
    output logic [WORD_SIZE-1:0]       prog_count,
    output logic [5:0]                 instr_opcode,
    output logic [4:0]                 write_reg_addr,
    output logic [WORD_SIZE-1:0]       write_reg_data,
    output logic                       reg_write_en,
    output logic                       instr_retired,
    output logic                       halted,
    output logic                       illegal
);
    localparam int unsigned RW = $clog2(NUM_REGS);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT
    } alu_fn_e;

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] ir_q, ir_d;
    logic [WORD_SIZE-1:0] a_q, a_d;
    logic [WORD_SIZE-1:0] b_q, b_d;
    logic [WORD_SIZE-1:0] alu_q, alu_d;
    logic [WORD_SIZE-1:0] mdr_q, mdr_d;
    logic                 illegal_q, illegal_d;
    logic [WORD_SIZE-1:0] rf_q [NUM_REGS];

    logic [5:0]           opcode, funct;
    logic [RW-1:0]        rs_idx, rt_idx, rd_idx;
    logic [WORD_SIZE-1:0] imm_sext, pc_plus4, jump_tgt;
    logic                 op_legal;

    logic [WORD_SIZE-1:0] alu_a, alu_b, alu_y;
    alu_fn_e              alu_fn;

    logic                  req_c, we_c, retire_c, rf_we_c;
    logic [ADDR_WIDTH-1:0] addr_c;
    logic [RW-1:0]         rf_waddr_c;
    logic [WORD_SIZE-1:0]  rf_wdata_c;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs_idx   = ir_q[21 +: RW];
    assign rt_idx   = ir_q[16 +: RW];
    assign rd_idx   = ir_q[11 +: RW];
    assign imm_sext = {{(WORD_SIZE-16){ir_q[15]}}, ir_q[15:0]};
    assign pc_plus4 = pc_q + WORD_SIZE'(4);
    assign jump_tgt = {pc_plus4[WORD_SIZE-1:28], ir_q[25:0], 2'b00};

    always_comb begin
        op_legal = 1'b0;
        unique case (opcode)
            OP_RTYPE: op_legal = (funct == FN_ADD) || (funct == FN_SUB) ||
                                 (funct == FN_AND) || (funct == FN_OR)  ||
                                 (funct == FN_NOR) || (funct == FN_SLT);
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    // Single shared ALU: computes the branch target in DECODE, the
    // register/immediate result or effective address in EXEC.
    always_comb begin
        alu_a  = a_q;
        alu_b  = imm_sext;
        alu_fn = ALU_ADD;
        if (state_q == S_DECODE) begin
            alu_a = pc_plus4;
            alu_b = imm_sext << 2;
        end else if (opcode == OP_RTYPE) begin
            alu_b = b_q;
            unique case (funct)
                FN_SUB:  alu_fn = ALU_SUB;
                FN_AND:  alu_fn = ALU_AND;
                FN_OR:   alu_fn = ALU_OR;
                FN_NOR:  alu_fn = ALU_NOR;
                FN_SLT:  alu_fn = ALU_SLT;
                default: alu_fn = ALU_ADD;
            endcase
        end
    end

    always_comb begin
        alu_y = '0;
        unique case (alu_fn)
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_NOR: alu_y = ~(alu_a | alu_b);
            ALU_SLT: alu_y = {{(WORD_SIZE-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_d      = alu_q;
        mdr_d      = mdr_q;
        illegal_d  = illegal_q;
        req_c      = 1'b0;
        we_c       = 1'b0;
        addr_c     = pc_q[ADDR_WIDTH-1:0];
        retire_c   = 1'b0;
        rf_we_c    = 1'b0;
        rf_waddr_c = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
        rf_wdata_c = (opcode == OP_LW) ? mdr_q : alu_q;

        unique case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_bus.mem_ready) begin
                    ir_d    = mem_bus.mem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = rf_q[rs_idx];
                b_d   = rf_q[rt_idx];
                alu_d = alu_y;
                if (!op_legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (opcode == OP_J) begin
                    pc_d     = jump_tgt;
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (opcode == OP_BEQ) begin
                    // ALUOut still holds the branch target from DECODE.
                    pc_d     = (a_q == b_q) ? alu_q : pc_plus4;
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    alu_d = alu_y;
                    if (alu_y[1:0] != 2'b00) begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end else begin
                        state_d = S_MEM;
                    end
                end else begin
                    alu_d   = alu_y;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                req_c  = 1'b1;
                we_c   = (opcode == OP_SW);
                addr_c = alu_q[ADDR_WIDTH-1:0];
                if (mem_bus.mem_ready) begin
                    if (opcode == OP_SW) begin
                        pc_d     = pc_plus4;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        mdr_d   = mem_bus.mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we_c  = (rf_waddr_c != '0);
                pc_d     = pc_plus4;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= WORD_SIZE'(RESET_PC);
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
            if (rf_we_c) rf_q[rf_waddr_c] <= rf_wdata_c;
        end
    end

    // Outputs are gated by rst so an access in flight is withdrawn the
    // moment reset asserts, not at the next edge.
    assign mem_bus.mem_req   = rst & req_c;
    assign mem_bus.mem_we    = rst & req_c & we_c;
    assign mem_bus.mem_addr  = rst ? addr_c : '0;
    assign mem_bus.mem_wdata = rst ? b_q : '0;

    assign prog_count     = pc_q;
    assign instr_opcode   = opcode;
    assign write_reg_addr = rst ? 5'(rf_waddr_c) : '0;
    assign write_reg_data = rst ? rf_wdata_c : '0;
    assign reg_write_en   = rst & rf_we_c;
    assign instr_retired  = rst & retire_c;
    assign halted         = rst & (state_q == S_HALT);
    assign illegal        = rst & illegal_q;
endmodule
